// File: rtl/serial_sum_sipo_pkg.sv
// serial_sum_sipo_pkg: shared state encoding and default widths for the serial adder datapath
package serial_sum_sipo_pkg;
  localparam int N_DEF = 8;
  localparam int CNT_W_DEF = 4;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  typedef enum logic [1:0] {
    IDLE    = S_IDLE,
    COLLECT = S_COLLECT,
    DONE    = S_DONE
  } state_t;
endpackage

// File: rtl/serial_sum_sipo_if.sv
// serial_sum_sipo_if: serial bit input and valid/ready result output of the sum collector
interface serial_sum_sipo_if import serial_sum_sipo_pkg::*; #(
  parameter int N = N_DEF
) ();
  logic         start;
  logic         bit_vld;
  logic         sum_bit;
  logic         carry;
  logic         ready;
  logic [N-1:0] sum;
  logic         cout;
  logic         valid;
  logic         busy;
  modport master (output start, bit_vld, sum_bit, carry, ready, input sum, cout, valid, busy);
  modport slave  (input start, bit_vld, sum_bit, carry, ready, output sum, cout, valid, busy);
endinterface

// File: rtl/sipo_shift_reg.sv
// sipo_shift_reg: N-bit shift-right capture register with clear and enable
module sipo_shift_reg #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic         din,
  output logic [N-1:0] q
);
  logic [N-1:0] q_d, q_q;
  // clear wins over shift; new bits enter at the MSB so the first bit ends at bit 0
  always_comb q_d = clr ? '0 : en ? {din, q_q[N-1:1]} : q_q;
  // capture register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q_q <= '0;
    else q_q <= q_d;
  assign q = q_q;
endmodule

// File: rtl/serial_sum_sipo.sv
// serial_sum_sipo: collects LSB-first sum bits and final carry into a word with valid/ready output
module serial_sum_sipo import serial_sum_sipo_pkg::*; #(
  parameter int N = N_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  serial_sum_sipo_if.slave bus
);
  state_t             state_d, state_q;
  logic [CNT_W-1:0]   cnt_d, cnt_q;
  logic               cout_d, cout_q;
  logic               clr, en;
  // next state, counter and shift control; a start in DONE only counts with the handshake
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    cout_d = cout_q;
    clr = 1'b0;
    en = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = COLLECT;
        cnt_d = '0;
        clr = 1'b1;
      end
      COLLECT: if (bus.start) begin
        cnt_d = '0;
        clr = 1'b1;
      end else if (bus.bit_vld) begin
        en = 1'b1;
        if (cnt_q == CNT_W'(N - 1)) begin
          cout_d = bus.carry;
          state_d = DONE;
        end else cnt_d = cnt_q + 1'b1;
      end
      DONE: if (bus.ready) begin
        state_d = bus.start ? COLLECT : IDLE;
        cnt_d = '0;
        clr = bus.start;
      end
      default: state_d = IDLE;
    endcase
  end
  // state, bit counter and carry registers
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      cout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      cout_q <= cout_d;
    end
  sipo_shift_reg #(.N(N)) u_shreg (
    .clk(i_clk),
    .rst_n(i_rst_n),
    .clr(clr),
    .en(en),
    .din(bus.sum_bit),
    .q(bus.sum)
  );
  assign bus.cout = cout_q;
  assign bus.valid = state_q == DONE;
  assign bus.busy = state_q == COLLECT;
endmodule
